decode_issue_stage: RTL and testbench

Decode/issue stage sitting directly between fetch and the two-cycle execute stage (X then X2, followed by WB). Each cycle it accepts one fetched instruction, cracks opcode/subcode/register fields, and checks a scalar and a vector scoreboard for RAW/WAW hazards. It then either issues the instruction into its output register or inserts a bubble and back-pressures fetch. It also handles execute back-pressure, jump flush, and halt.

---
 rtl/decode_issue_stage.sv | 160 ++++++++++++++++
 tb/tb_decode_issue_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: cracks fetched instructions, checks scalar/vector scoreboards, issues into X.
// Latency: 1 cycle fetch->d_valid when hazard-free; WB clears bypass into the same-cycle hazard check.
// Backpressure: d_stall holds fetch on hazard/x_stall/halt; x_stall freezes d_*; x_flush kills.
// Optional feature macro: DECODE_VSCOREBOARD_EN (per-register vector scoreboard; else one shared bit).
module decode_issue_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_valid,
  input  logic [15:0] f_pc,
  input  logic [15:0] f_ins,
  output logic        d_stall,
  input  logic        x_stall,
  input  logic        x_flush,
  input  logic        wb_valid,
  input  logic [3:0]  wb_rt,
  input  logic        wb_is_vector,
  output logic        d_valid,
  output logic [15:0] d_pc,
  output logic [15:0] d_ins,
  output logic [3:0]  d_opcode,
  output logic [3:0]  d_subcode,
  output logic [3:0]  d_ra,
  output logic [3:0]  d_rb,
  output logic [3:0]  d_rt,
  output logic [3:0]  d_rx,
  output logic        d_regData0,
  output logic        d_regData1,
  output logic        d_vregData0,
  output logic        d_vregData1,
  output logic        d_memData,
  output logic        d_halted
);

  logic [3:0]  op, sub, ra, rt, rx;
  logic        rd0, rd1, vrd0, vrd1, sWr, vWr, mem, isHalt;
  logic [15:0] sbusy, sbClr, sbEff, sbSet;
  logic        vHaz, hazard, issue;

`ifdef DECODE_VSCOREBOARD_EN
  logic [15:0] vbusy, vbClr, vbEff, vbSet;
`else
  logic        vbusy, vbEff;
`endif

  // Crack fields and derive read/write enables from the opcode map
  always_comb begin
    op     = f_ins[15:12];
    sub    = f_ins[7:4];
    ra     = f_ins[11:8];
    rt     = f_ins[3:0];
    rx     = f_ins[7:4];
    rd0    = 1'b0;
    rd1    = 1'b0;
    vrd0   = 1'b0;
    vrd1   = 1'b0;
    sWr    = 1'b0;
    vWr    = 1'b0;
    mem    = 1'b0;
    isHalt = 1'b0;
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3: begin rd0 = 1'b1; rd1 = 1'b1; sWr = 1'b1; end
      4'h4: sWr = 1'b1;
      4'h5: begin rx = rt; rd1 = 1'b1; sWr = 1'b1; end
      4'h6: begin rx = rt; rd0 = 1'b1; rd1 = 1'b1; end
      4'h7: begin
        mem = 1'b1;
        rd0 = 1'b1;
        // subcode 1 is st (reads rt as data); anything else behaves as ld
        if (sub == 4'h1) begin
          rx  = rt;
          rd1 = 1'b1;
        end else begin
          sWr = 1'b1;
        end
      end
      4'h8, 4'h9, 4'hA, 4'hB: begin vrd0 = 1'b1; vrd1 = 1'b1; vWr = 1'b1; end
      4'hC: begin mem = 1'b1; rd0 = 1'b1; vWr = 1'b1; end
      4'hD: begin mem = 1'b1; rd0 = 1'b1; rx = rt; vrd1 = 1'b1; end
      4'hE: begin vrd0 = 1'b1; vrd1 = 1'b1; sWr = 1'b1; end
      default: isHalt = 1'b1;
    endcase
  end

  // Scoreboard view with this cycle's WB retirement already cleared (bypass into hazard check)
  always_comb begin
    sbClr = (wb_valid && !wb_is_vector) ? (16'h0001 << wb_rt) : 16'h0000;
    sbEff = sbusy & ~sbClr;
    sbSet = (issue && sWr) ? (16'h0001 << rt) : 16'h0000;
`ifdef DECODE_VSCOREBOARD_EN
    vbClr = (wb_valid && wb_is_vector) ? (16'h0001 << wb_rt) : 16'h0000;
    vbEff = vbusy & ~vbClr;
    vbSet = (issue && vWr) ? (16'h0001 << rt) : 16'h0000;
    vHaz  = (vrd0 & vbEff[ra]) | (vrd1 & vbEff[rx]) | (vWr & vbEff[rt]);
`else
    // Single shared bit: any vector access waits for the outstanding vector writer
    vbEff = vbusy & ~(wb_valid & wb_is_vector);
    vHaz  = (vrd0 | vrd1 | vWr) & vbEff;
`endif
    hazard  = (rd0 & sbEff[ra]) | (rd1 & sbEff[rx]) | (sWr & sbEff[rt]) | vHaz;
    issue   = f_valid & ~hazard & ~x_stall & ~x_flush & ~d_halted;
    d_stall = f_valid & (hazard | x_stall | d_halted);
  end

  // Output register, scoreboards and halt flag; flush beats stall beats issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_valid     <= 1'b0;
      d_pc        <= '0;
      d_ins       <= '0;
      d_opcode    <= '0;
      d_subcode   <= '0;
      d_ra        <= '0;
      d_rb        <= '0;
      d_rt        <= '0;
      d_rx        <= '0;
      d_regData0  <= 1'b0;
      d_regData1  <= 1'b0;
      d_vregData0 <= 1'b0;
      d_vregData1 <= 1'b0;
      d_memData   <= 1'b0;
      d_halted    <= 1'b0;
      sbusy       <= '0;
      vbusy       <= '0;
    end else if (x_flush) begin
      // Only WB is older than X2 and it retires this same cycle, so every writer is gone
      d_valid <= 1'b0;
      sbusy   <= '0;
      vbusy   <= '0;
    end else begin
      sbusy <= sbEff | sbSet;
`ifdef DECODE_VSCOREBOARD_EN
      vbusy <= vbEff | vbSet;
`else
      vbusy <= vbEff | (issue & vWr);
`endif
      if (!x_stall) begin
        if (issue) begin
          d_valid     <= 1'b1;
          d_pc        <= f_pc;
          d_ins       <= f_ins;
          d_opcode    <= op;
          d_subcode   <= sub;
          d_ra        <= ra;
          d_rb        <= f_ins[7:4];
          d_rt        <= rt;
          d_rx        <= rx;
          d_regData0  <= rd0;
          d_regData1  <= rd1;
          d_vregData0 <= vrd0;
          d_vregData1 <= vrd1;
          d_memData   <= mem;
          if (isHalt) d_halted <= 1'b1;
        end else begin
          d_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
module tb_decode_issue_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        f_valid;
  logic [15:0] f_pc, f_ins;
  logic        d_stall, x_stall, x_flush, wb_valid, wb_is_vector;
  logic [3:0]  wb_rt;
  logic        d_valid;
  logic [15:0] d_pc, d_ins;
  logic [3:0]  d_opcode, d_subcode, d_ra, d_rb, d_rt, d_rx;
  logic        d_regData0, d_regData1, d_vregData0, d_vregData1, d_memData, d_halted;

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  decode_issue_stage dut (
    .clk(clk), .rst(rst), .f_valid(f_valid), .f_pc(f_pc), .f_ins(f_ins),
    .d_stall(d_stall), .x_stall(x_stall), .x_flush(x_flush),
    .wb_valid(wb_valid), .wb_rt(wb_rt), .wb_is_vector(wb_is_vector),
    .d_valid(d_valid), .d_pc(d_pc), .d_ins(d_ins), .d_opcode(d_opcode),
    .d_subcode(d_subcode), .d_ra(d_ra), .d_rb(d_rb), .d_rt(d_rt), .d_rx(d_rx),
    .d_regData0(d_regData0), .d_regData1(d_regData1),
    .d_vregData0(d_vregData0), .d_vregData1(d_vregData1),
    .d_memData(d_memData), .d_halted(d_halted)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; f_valid = 0; f_pc = 0; f_ins = 0;
    x_stall = 0; x_flush = 0; wb_valid = 0; wb_rt = 0; wb_is_vector = 0;
    #12;
    check("rst_dvalid", {15'd0, d_valid}, 16'd0);
    check("rst_halted", {15'd0, d_halted}, 16'd0);
    check("rst_sbusy", dut.sbusy, 16'h0000);
    check("rst_dins", d_ins, 16'h0000);
    check("rst_stall", {15'd0, d_stall}, 16'd0);
    rst = 1'b0;
    tick();

    // add r3=r1+r2
    f_valid = 1; f_pc = 16'h0010; f_ins = 16'h0123; #1;
    check("add_stall", {15'd0, d_stall}, 16'd0);
    tick();
    check("add_valid", {15'd0, d_valid}, 16'd1);
    check("add_op", {12'd0, d_opcode}, 16'h0);
    check("add_ra", {12'd0, d_ra}, 16'h1);
    check("add_rx", {12'd0, d_rx}, 16'h2);
    check("add_rt", {12'd0, d_rt}, 16'h3);
    check("add_pc", d_pc, 16'h0010);
    check("add_rd", {14'd0, d_regData0, d_regData1}, 16'h3);
    check("add_sbusy", dut.sbusy, 16'h0008);

    // sub r4=r3-r1: RAW on r3
    f_pc = 16'h0012; f_ins = 16'h1314; #1;
    check("sub_stall", {15'd0, d_stall}, 16'd1);
    tick();
    check("sub_bubble", {15'd0, d_valid}, 16'd0);
    check("sub_stall2", {15'd0, d_stall}, 16'd1);
    wb_valid = 1; wb_rt = 3; wb_is_vector = 0; #1;
    check("sub_wbbypass", {15'd0, d_stall}, 16'd0);
    tick();
    wb_valid = 0;
    check("sub_valid", {15'd0, d_valid}, 16'd1);
    check("sub_ra", {12'd0, d_ra}, 16'h3);
    check("sub_rx", {12'd0, d_rx}, 16'h1);
    check("sub_rt", {12'd0, d_rt}, 16'h4);
    check("sub_sbusy", dut.sbusy, 16'h0010);

    // movl r3 under x_stall for 3 cycles
    f_pc = 16'h0014; f_ins = 16'h4003; x_stall = 1; #1;
    check("xs_stall", {15'd0, d_stall}, 16'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("xs_hold_valid", {15'd0, d_valid}, 16'd1);
      check("xs_hold_ins", d_ins, 16'h1314);
      check("xs_hold_sbusy", dut.sbusy, 16'h0010);
      check("xs_dstall", {15'd0, d_stall}, 16'd1);
    end
    x_stall = 0;
    tick();
    check("movl_ins", d_ins, 16'h4003);
    check("movl_rd", {14'd0, d_regData0, d_regData1}, 16'h0);
    check("movl_sbusy", dut.sbusy, 16'h0018);

    // flush with d_valid=1, sbusy=0x0018
    f_valid = 0; x_flush = 1;
    tick();
    x_flush = 0;
    check("flush_valid", {15'd0, d_valid}, 16'd0);
    check("flush_sbusy", dut.sbusy, 16'h0000);

    // flush and stall together: flush wins
    f_valid = 1; f_ins = 16'h0123;
    tick();
    check("fs_pre_sbusy", dut.sbusy, 16'h0008);
    f_valid = 0; x_flush = 1; x_stall = 1;
    tick();
    x_flush = 0; x_stall = 0;
    check("fs_valid", {15'd0, d_valid}, 16'd0);
    check("fs_sbusy", dut.sbusy, 16'h0000);

    // vadd v2=v1+v0 then vld v5
    f_valid = 1; f_ins = 16'h8102;
    tick();
    check("vadd_valid", {15'd0, d_valid}, 16'd1);
    check("vadd_vrd", {12'd0, d_vregData0, d_vregData1, d_regData0, d_regData1}, 16'hC);
    f_ins = 16'hC005; #1;
`ifdef DECODE_VSCOREBOARD_EN
    check("vld_stall", {15'd0, d_stall}, 16'd0);
    tick();
`else
    check("vld_stall", {15'd0, d_stall}, 16'd1);
    tick();
    check("vld_bubble", {15'd0, d_valid}, 16'd0);
    wb_valid = 1; wb_rt = 2; wb_is_vector = 1; #1;
    check("vld_wbbypass", {15'd0, d_stall}, 16'd0);
    tick();
    wb_valid = 0; wb_is_vector = 0;
`endif
    check("vld_valid", {15'd0, d_valid}, 16'd1);
    check("vld_ins", d_ins, 16'hC005);
    check("vld_mem", {15'd0, d_memData}, 16'd1);
    check("vld_rd", {12'd0, d_vregData0, d_vregData1, d_regData0, d_regData1}, 16'h2);

    // add r3 issuing while WB retires r3: set wins
    f_ins = 16'h0123; wb_valid = 1; wb_rt = 3; wb_is_vector = 0;
    tick();
    wb_valid = 0;
    check("setwins_sbusy", dut.sbusy, 16'h0008);

    // st r3 -> [r2]: rx selects rt, stalls on r3
    f_ins = 16'h7213; #1;
    check("st_stall", {15'd0, d_stall}, 16'd1);
    tick();
    wb_valid = 1; wb_rt = 3; #1;
    tick();
    wb_valid = 0;
    check("st_valid", {15'd0, d_valid}, 16'd1);
    check("st_rx", {12'd0, d_rx}, 16'h3);
    check("st_sub", {12'd0, d_subcode}, 16'h1);
    check("st_mem", {15'd0, d_memData}, 16'd1);
    check("st_sbusy", dut.sbusy, 16'h0000);

    // halt then add
    f_ins = 16'hF000; #1;
    check("halt_stall", {15'd0, d_stall}, 16'd0);
    tick();
    check("halt_valid", {15'd0, d_valid}, 16'd1);
    check("halt_op", {12'd0, d_opcode}, 16'hF);
    check("halt_flag", {15'd0, d_halted}, 16'd1);
    f_ins = 16'h0123; #1;
    for (int i = 0; i < 3; i++) begin
      check("halted_stall", {15'd0, d_stall}, 16'd1);
      tick();
      check("halted_bubble", {15'd0, d_valid}, 16'd0);
    end
    rst = 1; #1;
    check("rst2_halted", {15'd0, d_halted}, 16'd0);
    check("rst2_valid", {15'd0, d_valid}, 16'd0);
    rst = 0; #1;
    tick();
    check("post_rst_valid", {15'd0, d_valid}, 16'd1);
    check("post_rst_ins", d_ins, 16'h0123);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
